calc_entry_ctrl: RTL and testbench
==================================

// Module: calc_entry_ctrl
// PURPOSE
//  Keypad-to-datapath sequencer for the calculator.
//  - Turns raw button levels into single key events.
//  - Builds the operand being typed as a calc_pkg::num_t.
//  - Tracks the accumulator, the pending operator and the memory register.
//  - Issues operations to the shared arithmetic unit over a valid/ready request and a valid response.
//  - Sits between the button matrix and the ALU/segment-display path; display_o feeds the segment encoder.
// PARAMETERS
//  DebounceCycles  16  stable-high cycles before a press counts (used only with CALC_DEBOUNCE_EN)
//  (digit count comes from calc_pkg::NumDigits; no local copy)
// PORTS
//  clk_i            in   1                  clock; single clock domain
//  rst_i            in   1                  reset, synchronous, active-high
//  buttons_i        in   $bits(buttons_t)   raw button levels, calc_pkg::buttons_t
//  alu_req_valid_o  out  1                  operation request valid
//  alu_req_ready_i  in   1                  ALU accepts request
//  alu_req_op_o     out  op_e               ADD/SUB/MUL/DIV/SQRT/PERCENT
//  alu_req_a_o      out  num_t              left operand
//  alu_req_b_o      out  num_t              right operand (ignored by ALU for unary ops)
//  alu_rsp_valid_i  in   1                  result valid (single-cycle pulse)
//  alu_rsp_i        in   num_t              result; .error flags overflow/div0/sqrt(-x)
//  display_o        out  num_t              value to show
//  display_on_o     out  1                  display enabled
//  busy_o           out  1                  request outstanding; key events dropped
// BEHAVIOUR
//  Reset: state OFF; all outputs 0; entry, acc, mem, pending cleared.
//  Key event:
//  - Registered rising edge (cur & ~prev) of buttons_i.
//  - More than one new edge in a cycle: all dropped.
//  - Any edge while in WAIT: dropped.
//  - Latency: buttons_i rises at cycle N; display_o/state update is visible after edge N+2.
//  States: OFF, ENTRY, RESULT, WAIT, ERROR.
//  - OFF: only ON is honoured -> clear entry/acc/pending -> ENTRY. display_on_o=0.
//  - Any state: OFF -> OFF. ON in ENTRY/RESULT/ERROR clears entry/acc/pending (mem kept) -> ENTRY.
//  - ERROR: display_o = last result (error=1); digits and operators ignored.
//  Digit entry (int_cnt/frac_cnt counters; value = sig*10^(exp-(N-1))):
//  - Integer digit, int_cnt=0, digit 0: ignored.
//  - Integer digit, first nonzero: sig[N-1]=d, exp=0, int_cnt=1.
//  - Later integer digits: sig[N-1-int_cnt]=d, exp++, int_cnt++.
//  - DOT: enter fraction phase. A second DOT is ignored.
//  - Fraction digit, int_cnt=0: sig[N-2-frac_cnt]=d (leading 0 implied).
//  - Fraction digit, otherwise: sig[N-1-int_cnt-frac_cnt]=d. frac_cnt++ in both cases.
//  - Capacity full (int_cnt+frac_cnt=N, or frac_cnt=N-1 with int_cnt=0): digit ignored.
//  - A digit in RESULT starts a fresh entry.
//  Binary op (ADD/SUB/MUL/DIV):
//  - No pending operator: acc <= display_o; pending <= op.
//  - Pending operator present: issue pending(acc, entry) -> WAIT; on response acc <= result, pending <= op, -> RESULT.
//  EQ:
//  - Pending present: issue pending(acc, entry); on response pending cleared, -> RESULT.
//  - No pending: no-op.
//  SQRT/PERCENT: issue op(display_o) -> WAIT; result replaces entry -> RESULT.
//  Memory:
//  - MEM_ADD/MEM_SUB issue ADD/SUB(mem, display_o) with destination=mem; display_o is unchanged.
//  - MEM_RC: entry <= mem -> RESULT.
//  Handshake:
//  - alu_req_valid_o rises the cycle after the key is decoded.
//  - op/a/b are held stable until valid & ready; valid drops the next cycle.
//  - busy_o=1 from request until the response is taken.
//  - alu_rsp_valid_i outside WAIT: ignored.
//  - Response with .error=1 -> ERROR, regardless of destination.
//  Reset mid-operation: the outstanding request is abandoned; a late response is ignored (state is not WAIT).
// CONFIGURATION
//  CALC_DEBOUNCE_EN:
//  - Defined: each button passes through a counter; its level counts as high only after DebounceCycles consecutive high samples, and low as soon as it drops.
//  - Adds DebounceCycles to the key latency.
//  - Undefined: raw levels go straight to edge detection; DebounceCycles is unused.
// STRUCTURE
//  calc_pkg additions:
//  - op_e (3-bit enum).
//  - ctrl_state_e.
//  - Reuse num_t, buttons_t, active_button_t, NumDigits.
//  Sub-module calc_key_decode:
//  - Optional debounce, edge detect, multi-press rejection.
//  - Outputs a one-cycle valid plus active_button_t.
//  Top: FSM, entry builder, acc/mem/pending registers, ALU request register.
// TESTING
//  - ON, 1,2,3 -> display_o sig={1,2,3,0..}, exp=2, sign=0, error=0.
//  - ON, 0,DOT,0,5 -> sig={0,0,5,0..}, exp=0. NumDigits+1 digit presses -> last digit ignored.
//  - 2,ADD,3,EQ with ready held low 3 cycles -> valid high 4 cycles, op=ADD, a=2, b=3 stable throughout; response 5 -> display 5.
//  - 2,MUL,3,ADD -> MUL(2,3) issued on ADD; display 6; then 4,EQ -> ADD(6,4) issued.
//  - DIV response with error=1 -> ERROR; digit 7 -> display unchanged; ON -> display 0, state ENTRY.
//  - NUM_1 and NUM_2 rise in the same cycle -> no change.
//  - With CALC_DEBOUNCE_EN: a high pulse shorter than DebounceCycles -> no event; a long one -> exactly one event.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared types for the calculator entry controller.
// Number format: value = sig * 10^(exp - (NumDigits-1)), sig[NumDigits-1] is the
// most significant digit.
package calc_pkg;

    localparam int NumDigits  = 8;
    localparam int IdxW       = $clog2(NumDigits);
    localparam int CntW       = $clog2(NumDigits + 1);
    localparam int NumButtons = 23;

    typedef logic [3:0] digit_t;

    typedef struct packed {
        logic                        sign;
        logic                        error;
        logic [4:0]                  exp;
        digit_t [NumDigits-1:0]      sig;
    } num_t;

    // Button index inside buttons_t; digits occupy 0..9 so the digit value is the index.
    typedef enum logic [4:0] {
        BTN_NUM_0   = 5'd0,
        BTN_NUM_1   = 5'd1,
        BTN_NUM_2   = 5'd2,
        BTN_NUM_3   = 5'd3,
        BTN_NUM_4   = 5'd4,
        BTN_NUM_5   = 5'd5,
        BTN_NUM_6   = 5'd6,
        BTN_NUM_7   = 5'd7,
        BTN_NUM_8   = 5'd8,
        BTN_NUM_9   = 5'd9,
        BTN_DOT     = 5'd10,
        BTN_ADD     = 5'd11,
        BTN_SUB     = 5'd12,
        BTN_MUL     = 5'd13,
        BTN_DIV     = 5'd14,
        BTN_EQ      = 5'd15,
        BTN_SQRT    = 5'd16,
        BTN_PERCENT = 5'd17,
        BTN_MEM_ADD = 5'd18,
        BTN_MEM_SUB = 5'd19,
        BTN_MEM_RC  = 5'd20,
        BTN_ON      = 5'd21,
        BTN_OFF     = 5'd22
    } active_button_t;

    typedef logic [NumButtons-1:0] buttons_t;

    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_DIV     = 3'd3,
        OP_SQRT    = 3'd4,
        OP_PERCENT = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_RESULT = 3'd2,
        ST_WAIT   = 3'd3,
        ST_ERROR  = 3'd4
    } ctrl_state_e;

    // Where an ALU result is written when it comes back.
    typedef enum logic [1:0] {
        DEST_CHAIN = 2'd0,  // binary op chained by a new operator: acc and display
        DEST_EQ    = 2'd1,  // equals: display, pending cleared
        DEST_ENTRY = 2'd2,  // unary op: display only
        DEST_MEM   = 2'd3   // memory accumulate: mem only
    } dest_e;

    function automatic logic is_digit(input active_button_t b);
        return b <= BTN_NUM_9;
    endfunction

    function automatic digit_t btn_digit(input active_button_t b);
        return b[3:0];
    endfunction

    function automatic op_e btn_op(input active_button_t b);
        op_e op;
        case (b)
            BTN_SUB:     op = OP_SUB;
            BTN_MUL:     op = OP_MUL;
            BTN_DIV:     op = OP_DIV;
            BTN_SQRT:    op = OP_SQRT;
            BTN_PERCENT: op = OP_PERCENT;
            default:     op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/calc_key_decode.sv
// calc_key_decode: turns raw button levels into one-cycle key events.
// Optional per-button debounce when CALC_DEBOUNCE_EN is defined.
module calc_key_decode
    import calc_pkg::*;
#(
    parameter int DebounceCycles = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  buttons_t       buttons_i,
    output logic           key_valid_o,
    output active_button_t key_o
);

    buttons_t       w_level;
    buttons_t       w_edge;
    logic           w_multi;
    active_button_t w_key;
    buttons_t       r_prev;
    logic           r_key_valid;
    active_button_t r_key;

`ifdef CALC_DEBOUNCE_EN
    localparam int DbW = $clog2(DebounceCycles + 1);

    logic [DbW-1:0] r_db_cnt [NumButtons];
    buttons_t       r_db_lvl;

    // Count consecutive high samples per button; the level rises after DebounceCycles of them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the counter array is small and feeds the level directly, so it is reset like any flop.
            for (int i = 0; i < NumButtons; i++) r_db_cnt[i] <= '0;
            r_db_lvl <= '0;
        end else begin
            for (int i = 0; i < NumButtons; i++) begin
                if (!buttons_i[i]) begin
                    r_db_cnt[i] <= '0;
                    r_db_lvl[i] <= 1'b0;
                end else begin
                    if (r_db_cnt[i] != DbW'(DebounceCycles)) r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    r_db_lvl[i] <= (r_db_cnt[i] >= DbW'(DebounceCycles - 1));
                end
            end
        end
    end

    assign w_level = r_db_lvl;
`else
    assign w_level = buttons_i;
`endif

    assign w_edge  = w_level & ~r_prev;
    assign w_multi = |(w_edge & (w_edge - buttons_t'(1)));

    // Encode the single new edge into a button code.
    always_comb begin
        w_key = BTN_NUM_0;
        for (int i = 0; i < NumButtons; i++) begin
            if (w_edge[i]) w_key = active_button_t'(5'(i));
        end
    end

    // Register the previous level and the decoded event; simultaneous edges are discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev      <= '0;
            r_key_valid <= 1'b0;
            r_key       <= BTN_NUM_0;
        end else begin
            r_prev      <= w_level;
            r_key_valid <= (|w_edge) && !w_multi;
            r_key       <= w_key;
        end
    end

    assign key_valid_o = r_key_valid;
    assign key_o       = r_key;

endmodule

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: keypad-to-ALU sequencer. Builds the typed operand, tracks the
// accumulator, pending operator and memory, and issues ALU requests.
// Optional debounce in calc_key_decode is enabled by defining CALC_DEBOUNCE_EN.
module calc_entry_ctrl
    import calc_pkg::*;
#(
    parameter int DebounceCycles = 16
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  buttons_t buttons_i,
    output logic     alu_req_valid_o,
    input  logic     alu_req_ready_i,
    output op_e      alu_req_op_o,
    output num_t     alu_req_a_o,
    output num_t     alu_req_b_o,
    input  logic     alu_rsp_valid_i,
    input  num_t     alu_rsp_i,
    output num_t     display_o,
    output logic     display_on_o,
    output logic     busy_o
);

    logic           w_key_valid;
    active_button_t w_key;

    calc_key_decode #(
        .DebounceCycles (DebounceCycles)
    ) u_key_decode (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .buttons_i   (buttons_i),
        .key_valid_o (w_key_valid),
        .key_o       (w_key)
    );

    ctrl_state_e     r_state,      w_state_nxt;
    num_t            r_entry,      w_entry_nxt;
    logic [CntW-1:0] r_int_cnt,    w_int_nxt;
    logic [CntW-1:0] r_frac_cnt,   w_frac_nxt;
    logic            r_frac_phase, w_phase_nxt;
    num_t            r_acc,        w_acc_nxt;
    num_t            r_mem,        w_mem_nxt;
    num_t            r_result,     w_result_nxt;
    logic            r_pend_valid, w_pend_valid_nxt;
    op_e             r_pend_op,    w_pend_op_nxt;
    op_e             r_next_op,    w_next_op_nxt;
    dest_e           r_dest,       w_dest_nxt;
    logic            r_req_valid,  w_req_valid_nxt;
    op_e             r_req_op,     w_req_op_nxt;
    num_t            r_req_a,      w_req_a_nxt;
    num_t            r_req_b,      w_req_b_nxt;

    // Entry state a digit or DOT builds on: a key in RESULT starts a fresh operand.
    num_t            w_base_entry;
    logic [CntW-1:0] w_base_int;
    logic [CntW-1:0] w_base_frac;
    logic            w_base_phase;
    logic            w_full;
    logic [IdxW-1:0] w_idx;
    digit_t          w_digit;

    logic            w_issue;
    op_e             w_issue_op;
    num_t            w_issue_a;
    num_t            w_issue_b;
    dest_e           w_issue_dest;

    num_t            w_display;

    // Next-state, entry builder, operator sequencing and ALU request logic.
    always_comb begin
        // NOTE: every target gets its hold value first, so no path can infer a latch.
        w_state_nxt      = r_state;
        w_entry_nxt      = r_entry;
        w_int_nxt        = r_int_cnt;
        w_frac_nxt       = r_frac_cnt;
        w_phase_nxt      = r_frac_phase;
        w_acc_nxt        = r_acc;
        w_mem_nxt        = r_mem;
        w_result_nxt     = r_result;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_op_nxt    = r_pend_op;
        w_next_op_nxt    = r_next_op;
        w_dest_nxt       = r_dest;
        w_req_valid_nxt  = r_req_valid;
        w_req_op_nxt     = r_req_op;
        w_req_a_nxt      = r_req_a;
        w_req_b_nxt      = r_req_b;

        w_issue      = 1'b0;
        w_issue_op   = OP_ADD;
        w_issue_a    = '0;
        w_issue_b    = '0;
        w_issue_dest = DEST_ENTRY;
        w_idx        = '0;
        w_digit      = btn_digit(w_key);

        if (r_state == ST_RESULT) begin
            w_base_entry = '0;
            w_base_int   = '0;
            w_base_frac  = '0;
            w_base_phase = 1'b0;
        end else begin
            w_base_entry = r_entry;
            w_base_int   = r_int_cnt;
            w_base_frac  = r_frac_cnt;
            w_base_phase = r_frac_phase;
        end

        w_full = (w_base_int + w_base_frac == CntW'(NumDigits))
              || (w_base_int == '0 && w_base_frac == CntW'(NumDigits - 1));

        // The request is held until accepted.
        if (r_req_valid && alu_req_ready_i) w_req_valid_nxt = 1'b0;

        if (r_state == ST_WAIT) begin
            if (alu_rsp_valid_i) begin
                w_req_valid_nxt = 1'b0;
                w_result_nxt    = alu_rsp_i;
                if (alu_rsp_i.error) begin
                    w_state_nxt = ST_ERROR;
                end else begin
                    w_state_nxt = ST_RESULT;
                    case (r_dest)
                        DEST_CHAIN: begin
                            w_acc_nxt        = alu_rsp_i;
                            w_entry_nxt      = alu_rsp_i;
                            w_pend_op_nxt    = r_next_op;
                            w_pend_valid_nxt = 1'b1;
                        end
                        DEST_EQ: begin
                            w_entry_nxt      = alu_rsp_i;
                            w_pend_valid_nxt = 1'b0;
                        end
                        DEST_ENTRY: w_entry_nxt = alu_rsp_i;
                        default:    w_mem_nxt   = alu_rsp_i;
                    endcase
                end
            end
        end else if (w_key_valid) begin
            if (w_key == BTN_OFF) begin
                w_state_nxt = ST_OFF;
            end else if (w_key == BTN_ON) begin
                w_state_nxt      = ST_ENTRY;
                w_entry_nxt      = '0;
                w_int_nxt        = '0;
                w_frac_nxt       = '0;
                w_phase_nxt      = 1'b0;
                w_acc_nxt        = '0;
                w_pend_valid_nxt = 1'b0;
            end else if (r_state == ST_ENTRY || r_state == ST_RESULT) begin
                if (is_digit(w_key)) begin
                    w_state_nxt = ST_ENTRY;
                    w_entry_nxt = w_base_entry;
                    w_int_nxt   = w_base_int;
                    w_frac_nxt  = w_base_frac;
                    w_phase_nxt = w_base_phase;
                    if (!w_base_phase) begin
                        if (w_base_int == '0) begin
                            if (w_digit != '0) begin
                                w_entry_nxt.sig[NumDigits-1] = w_digit;
                                w_entry_nxt.exp              = '0;
                                w_int_nxt                    = CntW'(1);
                            end
                        end else if (w_base_int != CntW'(NumDigits)) begin
                            w_idx                  = IdxW'(NumDigits - 1) - IdxW'(w_base_int);
                            w_entry_nxt.sig[w_idx] = w_digit;
                            w_entry_nxt.exp        = w_base_entry.exp + 5'd1;
                            w_int_nxt              = w_base_int + 1'b1;
                        end
                    end else if (!w_full) begin
                        if (w_base_int == '0)
                            w_idx = IdxW'(NumDigits - 2) - IdxW'(w_base_frac);
                        else
                            w_idx = IdxW'(NumDigits - 1) - IdxW'(w_base_int) - IdxW'(w_base_frac);
                        w_entry_nxt.sig[w_idx] = w_digit;
                        w_frac_nxt             = w_base_frac + 1'b1;
                    end
                end else begin
                    case (w_key)
                        BTN_DOT: begin
                            w_state_nxt = ST_ENTRY;
                            w_entry_nxt = w_base_entry;
                            w_int_nxt   = w_base_int;
                            w_frac_nxt  = w_base_frac;
                            w_phase_nxt = 1'b1;
                        end
                        BTN_ADD, BTN_SUB, BTN_MUL, BTN_DIV: begin
                            if (!r_pend_valid) begin
                                w_acc_nxt        = r_entry;
                                w_pend_op_nxt    = btn_op(w_key);
                                w_pend_valid_nxt = 1'b1;
                                w_state_nxt      = ST_RESULT;
                            end else begin
                                w_issue       = 1'b1;
                                w_issue_op    = r_pend_op;
                                w_issue_a     = r_acc;
                                w_issue_b     = r_entry;
                                w_issue_dest  = DEST_CHAIN;
                                w_next_op_nxt = btn_op(w_key);
                            end
                        end
                        BTN_EQ: begin
                            if (r_pend_valid) begin
                                w_issue      = 1'b1;
                                w_issue_op   = r_pend_op;
                                w_issue_a    = r_acc;
                                w_issue_b    = r_entry;
                                w_issue_dest = DEST_EQ;
                            end
                        end
                        BTN_SQRT, BTN_PERCENT: begin
                            w_issue      = 1'b1;
                            w_issue_op   = btn_op(w_key);
                            w_issue_a    = r_entry;
                            w_issue_dest = DEST_ENTRY;
                        end
                        BTN_MEM_ADD, BTN_MEM_SUB: begin
                            w_issue      = 1'b1;
                            w_issue_op   = (w_key == BTN_MEM_ADD) ? OP_ADD : OP_SUB;
                            w_issue_a    = r_mem;
                            w_issue_b    = r_entry;
                            w_issue_dest = DEST_MEM;
                        end
                        BTN_MEM_RC: begin
                            w_entry_nxt = r_mem;
                            w_int_nxt   = '0;
                            w_frac_nxt  = '0;
                            w_phase_nxt = 1'b0;
                            w_state_nxt = ST_RESULT;
                        end
                        default: ;
                    endcase
                end
            end
        end

        if (w_issue) begin
            w_req_valid_nxt = 1'b1;
            w_req_op_nxt    = w_issue_op;
            w_req_a_nxt     = w_issue_a;
            w_req_b_nxt     = w_issue_b;
            w_dest_nxt      = w_issue_dest;
            w_state_nxt     = ST_WAIT;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_OFF;
            r_entry      <= '0;
            r_int_cnt    <= '0;
            r_frac_cnt   <= '0;
            r_frac_phase <= 1'b0;
            r_acc        <= '0;
            r_mem        <= '0;
            r_result     <= '0;
            r_pend_valid <= 1'b0;
            r_pend_op    <= OP_ADD;
            r_next_op    <= OP_ADD;
            r_dest       <= DEST_ENTRY;
            r_req_valid  <= 1'b0;
            r_req_op     <= OP_ADD;
            r_req_a      <= '0;
            r_req_b      <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register reading pre-edge values.
            r_state      <= w_state_nxt;
            r_entry      <= w_entry_nxt;
            r_int_cnt    <= w_int_nxt;
            r_frac_cnt   <= w_frac_nxt;
            r_frac_phase <= w_phase_nxt;
            r_acc        <= w_acc_nxt;
            r_mem        <= w_mem_nxt;
            r_result     <= w_result_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_op    <= w_pend_op_nxt;
            r_next_op    <= w_next_op_nxt;
            r_dest       <= w_dest_nxt;
            r_req_valid  <= w_req_valid_nxt;
            r_req_op     <= w_req_op_nxt;
            r_req_a      <= w_req_a_nxt;
            r_req_b      <= w_req_b_nxt;
        end
    end

    // Display source: blank when off, last (failed) result in ERROR, otherwise the entry.
    always_comb begin
        w_display = r_entry;
        if (r_state == ST_OFF) begin
            w_display = '0;
        end else if (r_state == ST_ERROR) begin
            w_display       = r_result;
            w_display.error = 1'b1;
        end
    end

    assign display_o       = w_display;
    assign display_on_o    = (r_state != ST_OFF);
    assign busy_o          = (r_state == ST_WAIT);
    assign alu_req_valid_o = r_req_valid;
    assign alu_req_op_o    = r_req_op;
    assign alu_req_a_o     = r_req_a;
    assign alu_req_b_o     = r_req_b;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// tb_calc_entry_ctrl: directed bench for calc_entry_ctrl with a hand-driven ALU.
module tb_calc_entry_ctrl;
    import calc_pkg::*;

    localparam int DB = 16;
`ifdef CALC_DEBOUNCE_EN
    localparam int HOLD = DB + 2;
`else
    localparam int HOLD = 2;
`endif
    localparam int SETTLE = 4;

    logic     clk_i = 1'b0;
    logic     rst_i;
    buttons_t buttons_i;
    logic     alu_req_valid_o;
    logic     alu_req_ready_i;
    op_e      alu_req_op_o;
    num_t     alu_req_a_o;
    num_t     alu_req_b_o;
    logic     alu_rsp_valid_i;
    num_t     alu_rsp_i;
    num_t     display_o;
    logic     display_on_o;
    logic     busy_o;

    int total = 0;
    int bad   = 0;

    calc_entry_ctrl #(.DebounceCycles(DB)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .buttons_i       (buttons_i),
        .alu_req_valid_o (alu_req_valid_o),
        .alu_req_ready_i (alu_req_ready_i),
        .alu_req_op_o    (alu_req_op_o),
        .alu_req_a_o     (alu_req_a_o),
        .alu_req_b_o     (alu_req_b_o),
        .alu_rsp_valid_i (alu_rsp_valid_i),
        .alu_rsp_i       (alu_rsp_i),
        .display_o       (display_o),
        .display_on_o    (display_on_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic num_t mk(input logic [4:0] e, input logic [31:0] s);
        num_t n;
        n     = '0;
        n.exp = e;
        n.sig = s;
        return n;
    endfunction

    function automatic buttons_t mask(input active_button_t b);
        buttons_t m;
        m    = '0;
        m[b] = 1'b1;
        return m;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_num(input string tag, input num_t obs, input num_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_op(input string tag, input op_e obs, input op_e exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press_raw(input buttons_t m, input int hold, input int settle);
        @(posedge clk_i);
        #1 buttons_i = m;
        repeat (hold) @(posedge clk_i);
        #1 buttons_i = '0;
        repeat (settle) @(posedge clk_i);
        #1;
    endtask

    task automatic tap(input active_button_t b);
        press_raw(mask(b), HOLD, SETTLE);
    endtask

    task automatic go(input active_button_t b);
        press_raw(mask(b), HOLD, 0);
    endtask

    // Accept one request after n_wait cycles of ready low, checking it stays stable, then respond.
    task automatic serve(input string tag, input op_e eop, input num_t ea, input num_t eb,
                         input int n_wait, input num_t rsp);
        int waited;
        waited = 0;
        @(negedge clk_i);
        while (alu_req_valid_o !== 1'b1 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        check_bit({tag, "_req_seen"}, alu_req_valid_o, 1'b1);
        if (alu_req_valid_o === 1'b1) begin
            for (int k = 0; k <= n_wait; k++) begin
                if (k > 0) @(negedge clk_i);
                check_bit({tag, "_valid"}, alu_req_valid_o, 1'b1);
                check_bit({tag, "_busy"}, busy_o, 1'b1);
                check_op({tag, "_op"}, alu_req_op_o, eop);
                check_num({tag, "_a"}, alu_req_a_o, ea);
                check_num({tag, "_b"}, alu_req_b_o, eb);
                if (k == n_wait) alu_req_ready_i = 1'b1;
            end
            @(negedge clk_i);
            alu_req_ready_i = 1'b0;
            check_bit({tag, "_valid_drop"}, alu_req_valid_o, 1'b0);
            check_bit({tag, "_busy_hold"}, busy_o, 1'b1);
            alu_rsp_valid_i = 1'b1;
            alu_rsp_i       = rsp;
            @(negedge clk_i);
            alu_rsp_valid_i = 1'b0;
            alu_rsp_i       = '0;
            check_bit({tag, "_busy_done"}, busy_o, 1'b0);
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        num_t err_rsp;
        int   waited;
        rst_i           = 1'b1;
        buttons_i       = '0;
        alu_req_ready_i = 1'b0;
        alu_rsp_valid_i = 1'b0;
        alu_rsp_i       = '0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state.
        check_num("rst_display", display_o, '0);
        check_bit("rst_on", display_on_o, 1'b0);
        check_bit("rst_valid", alu_req_valid_o, 1'b0);
        check_bit("rst_busy", busy_o, 1'b0);

        // OFF ignores digits; ON enables the display.
        tap(BTN_NUM_5);
        check_num("off_digit", display_o, '0);
        check_bit("off_on", display_on_o, 1'b0);
        tap(BTN_ON);
        check_bit("on_on", display_on_o, 1'b1);
        check_num("on_display", display_o, '0);

        // Integer entry 1,2,3.
        tap(BTN_NUM_1); tap(BTN_NUM_2); tap(BTN_NUM_3);
        check_num("int_123", display_o, mk(5'd2, 32'h1230_0000));

        // Fraction entry 0 . 0 5, second DOT ignored, then 7.
        tap(BTN_ON); tap(BTN_NUM_0); tap(BTN_DOT); tap(BTN_NUM_0); tap(BTN_NUM_5);
        check_num("frac_005", display_o, mk(5'd0, 32'h0050_0000));
        tap(BTN_DOT); tap(BTN_NUM_7);
        check_num("frac_0057", display_o, mk(5'd0, 32'h0057_0000));

        // NumDigits+1 digits: the last one is ignored.
        tap(BTN_ON);
        for (int d = 1; d <= NumDigits + 1; d++) tap(active_button_t'(5'(d)));
        check_num("capacity", display_o, mk(5'd7, 32'h1234_5678));

        // 2 + 3 = with ready held low for 3 cycles.
        tap(BTN_ON); tap(BTN_NUM_2); tap(BTN_ADD);
        check_bit("first_op_no_req", alu_req_valid_o, 1'b0);
        check_num("first_op_display", display_o, mk(5'd0, 32'h2000_0000));
        tap(BTN_NUM_3);
        go(BTN_EQ);
        serve("add", OP_ADD, mk(5'd0, 32'h2000_0000), mk(5'd0, 32'h3000_0000), 3,
              mk(5'd0, 32'h5000_0000));
        check_num("add_display", display_o, mk(5'd0, 32'h5000_0000));

        // 2 * 3 + 4 = : chained operator issues MUL on ADD.
        tap(BTN_ON); tap(BTN_NUM_2); tap(BTN_MUL); tap(BTN_NUM_3);
        go(BTN_ADD);
        serve("chain_mul", OP_MUL, mk(5'd0, 32'h2000_0000), mk(5'd0, 32'h3000_0000), 0,
              mk(5'd0, 32'h6000_0000));
        check_num("chain_display", display_o, mk(5'd0, 32'h6000_0000));
        tap(BTN_NUM_4);
        go(BTN_EQ);
        serve("chain_add", OP_ADD, mk(5'd0, 32'h6000_0000), mk(5'd0, 32'h4000_0000), 1,
              mk(5'd1, 32'h1000_0000));
        check_num("chain_eq_display", display_o, mk(5'd1, 32'h1000_0000));

        // 8 / 0 = : error response.
        err_rsp       = '0;
        err_rsp.error = 1'b1;
        tap(BTN_ON); tap(BTN_NUM_8); tap(BTN_DIV); tap(BTN_NUM_0);
        go(BTN_EQ);
        serve("div0", OP_DIV, mk(5'd0, 32'h8000_0000), '0, 0, err_rsp);
        check_num("err_display", display_o, err_rsp);
        tap(BTN_NUM_7);
        check_num("err_digit_ignored", display_o, err_rsp);
        tap(BTN_ON);
        check_num("err_on_clear", display_o, '0);
        check_bit("err_on_display_on", display_on_o, 1'b1);
        tap(BTN_NUM_4);
        check_num("err_on_entry", display_o, mk(5'd0, 32'h4000_0000));

        // Two simultaneous edges are dropped.
        tap(BTN_ON); tap(BTN_NUM_3);
        press_raw(mask(BTN_NUM_1) | mask(BTN_NUM_2), HOLD, SETTLE);
        check_num("multi_press", display_o, mk(5'd0, 32'h3000_0000));
        tap(BTN_NUM_5);
        check_num("after_multi", display_o, mk(5'd1, 32'h3500_0000));

        // Response outside WAIT is ignored.
        @(negedge clk_i);
        alu_rsp_valid_i = 1'b1;
        alu_rsp_i       = mk(5'd0, 32'h9900_0000);
        @(negedge clk_i);
        alu_rsp_valid_i = 1'b0;
        alu_rsp_i       = '0;
        @(negedge clk_i);
        check_num("stray_rsp", display_o, mk(5'd1, 32'h3500_0000));

        // SQRT, then memory add and recall across ON.
        tap(BTN_ON); tap(BTN_NUM_9);
        go(BTN_SQRT);
        serve("sqrt", OP_SQRT, mk(5'd0, 32'h9000_0000), '0, 0, mk(5'd0, 32'h3000_0000));
        check_num("sqrt_display", display_o, mk(5'd0, 32'h3000_0000));
        go(BTN_MEM_ADD);
        serve("madd", OP_ADD, '0, mk(5'd0, 32'h3000_0000), 0, mk(5'd0, 32'h3000_0000));
        check_num("madd_display", display_o, mk(5'd0, 32'h3000_0000));
        tap(BTN_ON);
        check_num("mem_on_clear", display_o, '0);
        tap(BTN_MEM_RC);
        check_num("mem_recall", display_o, mk(5'd0, 32'h3000_0000));

        // Reset with a request outstanding; a late response is ignored.
        tap(BTN_NUM_2);
        go(BTN_SQRT);
        waited = 0;
        while (alu_req_valid_o !== 1'b1 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        check_bit("midop_req", alu_req_valid_o, 1'b1);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check_bit("midop_valid", alu_req_valid_o, 1'b0);
        check_bit("midop_busy", busy_o, 1'b0);
        check_bit("midop_on", display_on_o, 1'b0);
        @(negedge clk_i);
        alu_rsp_valid_i = 1'b1;
        alu_rsp_i       = mk(5'd0, 32'h7000_0000);
        @(negedge clk_i);
        alu_rsp_valid_i = 1'b0;
        alu_rsp_i       = '0;
        @(negedge clk_i);
        check_num("late_rsp", display_o, '0);
        tap(BTN_ON);
        tap(BTN_NUM_2);
        check_num("after_reset_entry", display_o, mk(5'd0, 32'h2000_0000));

`ifdef CALC_DEBOUNCE_EN
        // Short pulse is filtered; long pulse gives exactly one digit.
        tap(BTN_ON);
        press_raw(mask(BTN_NUM_6), DB - 2, DB + SETTLE);
        check_num("db_short", display_o, '0);
        press_raw(mask(BTN_NUM_6), DB + 6, SETTLE);
        check_num("db_long", display_o, mk(5'd0, 32'h6000_0000));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
